reg_file_mp: RTL and testbench
==============================

// Module: reg_file_mp
// PURPOSE
//  Parametrised multi-port GPR file for dual-issue pipeline: NUM_RD read, NUM_WR byte-enabled write ports.
//  Same-cycle write->read bypass per byte, register 0 hardwired to zero, per-register busy scoreboard.
//  After reset, hardware init sweep zeroes every entry; issue stage stalls until rf_ready.
// PARAMETERS
//  DATA_WIDTH  32  register width in bits; must be a multiple of 8.
//  ADDR_WIDTH   5  address bits; depth = 2**ADDR_WIDTH.
//  NUM_RD       4  read ports.
//  NUM_WR       2  write ports; higher index has higher priority.
// PORTS
//  clk       in   1                    clock
//  rst       in   1                    async reset, active-low
//  waddr     in   NUM_WR*ADDR_WIDTH    write addresses, port i at [i*AW +: AW]
//  byte_wen  in   NUM_WR*DATA_WIDTH/8  byte write enables per port
//  wdata     in   NUM_WR*DATA_WIDTH    write data per port
//  wclr      in   NUM_WR               port i write is a producer's final write: clear busy[waddr_i]
//  raddr     in   NUM_RD*ADDR_WIDTH    read addresses
//  rdata     out  NUM_RD*DATA_WIDTH    read data (combinational)
//  rbusy     out  NUM_RD               busy bit of raddr_j after this cycle's clears
//  set_en    in   1                    mark set_addr busy (instruction issued)
//  set_addr  in   ADDR_WIDTH           register to mark busy
//  rf_ready  out  1                    init sweep done; writes/sets accepted
// BEHAVIOUR
//  Reset (rst=0, async): FSM -> INIT, sweep ptr=1, busy[] all 0, rf_ready=0.
//  FSM INIT: each clk writes 0 to entry ptr, ptr++; at ptr=2**AW-1 write, go RUN next cycle.
//   Sweep takes 2**AW-1 cycles; rf_ready=1 from first RUN cycle. Entry 0 never written.
//  In INIT: wen/wclr/set_en ignored; rdata all 0; rbusy all 0.
//  Reset mid-sweep or mid-RUN restarts INIT from ptr=1; no partial state survives.
//  RUN write: per byte b, port i writes rf[waddr_i][8b+:8] when byte_wen_i[b] and waddr_i!=0.
//   Two ports same addr, same byte: highest-index port wins; disjoint bytes both land.
//  Read: raddr_j==0 -> rdata_j=0. Else per byte: highest-index port with waddr==raddr_j and
//   byte_wen[b] set supplies wdata byte (bypass); otherwise stored byte. Zero-cycle latency.
//  Scoreboard (RUN): busy[a] <= 1 on set_en, set_addr=a!=0; <= 0 on wclr_i with waddr_i=a.
//   set and clear same addr same cycle: set wins (new producer). set_addr=0 ignored; busy[0] always 0.
//   wclr with all byte_wen=0 still clears busy. rbusy_j = busy[raddr_j] & ~(any wclr to raddr_j this cycle),
//   but a same-cycle set_en to raddr_j does not raise rbusy_j until next cycle.
//  Widths: byte-enable vector DATA_WIDTH/8 per port; no sign/zero extension, partial bytes retain old value.
// TESTING
//  1. Reset, release rst -> rf_ready 0 for 31 cycles (AW=5), 1 on 32nd; all rdata 0 throughout and after.
//  2. Write port0 addr 5 wdata 0x11223344 wen 4'b1111; same cycle raddr0=5 -> rdata0 0x11223344; next cycle stored.
//  3. Port0 addr7 0xAAAAAAAA wen 1111, port1 addr7 0x000000BB wen 0001 -> rf[7]=0xAAAAAABB, bypass read shows same.
//  4. Write addr 0 0xFFFFFFFF all ports -> raddr=0 reads 0; set_en addr 0 -> rbusy 0.
//  5. set_en addr 9 -> next cycle rbusy=1; wclr port1 addr 9 -> rbusy 0 same cycle; set+wclr addr9 together -> busy 1.
//  6. Assert rst mid-sweep (ptr=10) after writes ignored -> sweep restarts, rf_ready 31 cycles after release, busy all 0.

Source files
------------

// File: rtl/reg_file_mp_if.sv
// Register-file access bundle: write ports, read ports, scoreboard set, init status.
//  master: issue/writeback side (drives addresses, data, enables, set/clear).
//  slave : register file (returns rdata, rbusy, rf_ready).
interface rf_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_RD     = 4,
  parameter int unsigned NUM_WR     = 2
);
  localparam int unsigned NB = DATA_WIDTH / 8;

  logic [NUM_WR*ADDR_WIDTH-1:0] waddr;
  logic [NUM_WR*NB-1:0]         byte_wen;
  logic [NUM_WR*DATA_WIDTH-1:0] wdata;
  logic [NUM_WR-1:0]            wclr;
  logic [NUM_RD*ADDR_WIDTH-1:0] raddr;
  logic [NUM_RD*DATA_WIDTH-1:0] rdata;
  logic [NUM_RD-1:0]            rbusy;
  logic                         set_en;
  logic [ADDR_WIDTH-1:0]        set_addr;
  logic                         rf_ready;

  modport master (
    output waddr, byte_wen, wdata, wclr, raddr, set_en, set_addr,
    input  rdata, rbusy, rf_ready
  );

  modport slave (
    input  waddr, byte_wen, wdata, wclr, raddr, set_en, set_addr,
    output rdata, rbusy, rf_ready
  );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port GPR file with per-byte write bypass, hardwired r0, busy scoreboard
// and a post-reset zeroing sweep.
//  clk   : clock
//  rst   : asynchronous reset, active-low
//  bus   : rf_if slave - NUM_WR byte-enabled write ports (wclr clears busy),
//          NUM_RD combinational read ports with bypass and rbusy,
//          set_en/set_addr marks a register busy, rf_ready high once swept.
module reg_file_mp #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_RD     = 4,
  parameter int unsigned NUM_WR     = 2
) (
  input logic clk,
  input logic rst,
  rf_if.slave bus
);
  localparam int unsigned NB    = DATA_WIDTH / 8;
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic                    rf_ready_q, rf_ready_d;
  logic [DEPTH-1:0]        busy_q, busy_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0]   wa [NUM_WR];
  logic [ADDR_WIDTH-1:0]   ra [NUM_RD];
  logic                    run;
  logic [NUM_RD*DATA_WIDTH-1:0] rdata_c;
  logic [NUM_RD-1:0]       rbusy_c;

  // Unpack flat address buses
  always_comb begin
    for (int i = 0; i < NUM_WR; i++) wa[i] = bus.waddr[i*ADDR_WIDTH +: ADDR_WIDTH];
    for (int j = 0; j < NUM_RD; j++) ra[j] = bus.raddr[j*ADDR_WIDTH +: ADDR_WIDTH];
  end

  assign run = (state_q == ST_RUN);

  // State, sweep pointer, ready flag and scoreboard registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_INIT;
      ptr_q      <= ADDR_WIDTH'(1);
      rf_ready_q <= 1'b0;
      busy_q     <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rf_ready_q <= rf_ready_d;
      busy_q     <= busy_d;
    end
  end

  // Next state: sweep entries 1..DEPTH-1, then run the scoreboard
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    busy_d  = busy_q;
    case (state_q)
      ST_INIT: begin
        ptr_d = ptr_q + ADDR_WIDTH'(1);
        if (ptr_q == {ADDR_WIDTH{1'b1}}) state_d = ST_RUN;
      end
      ST_RUN: begin
        for (int i = 0; i < NUM_WR; i++)
          if (bus.wclr[i]) busy_d[wa[i]] = 1'b0;
        // Set applied after clears: a new producer overrides a retiring one
        if (bus.set_en) busy_d[bus.set_addr] = 1'b1;
        busy_d[0] = 1'b0;
      end
      default: state_d = ST_INIT;
    endcase
    rf_ready_d = (state_d == ST_RUN);
  end

  // Storage: sweep zeroing, then byte writes with higher port index last (wins)
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem_q[ptr_q] <= '0;
    end else begin
      for (int i = 0; i < NUM_WR; i++)
        for (int b = 0; b < NB; b++)
          if (bus.byte_wen[i*NB + b] && (wa[i] != '0))
            mem_q[wa[i]][b*8 +: 8] <= bus.wdata[i*DATA_WIDTH + b*8 +: 8];
    end
  end

  // Read ports: stored value overlaid by same-cycle writes per byte
  always_comb begin
    rdata_c = '0;
    rbusy_c = '0;
    for (int j = 0; j < NUM_RD; j++) begin
      if (run && (ra[j] != '0)) begin
        rdata_c[j*DATA_WIDTH +: DATA_WIDTH] = mem_q[ra[j]];
        for (int i = 0; i < NUM_WR; i++)
          for (int b = 0; b < NB; b++)
            if ((wa[i] == ra[j]) && bus.byte_wen[i*NB + b])
              rdata_c[j*DATA_WIDTH + b*8 +: 8] = bus.wdata[i*DATA_WIDTH + b*8 +: 8];
      end
      // Same-cycle clears drop rbusy immediately; same-cycle sets show next cycle
      if (run) begin
        rbusy_c[j] = busy_q[ra[j]];
        for (int i = 0; i < NUM_WR; i++)
          if (bus.wclr[i] && (wa[i] == ra[j])) rbusy_c[j] = 1'b0;
      end
    end
  end

  assign bus.rdata    = rdata_c;
  assign bus.rbusy    = rbusy_c;
  assign bus.rf_ready = rf_ready_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Randomised and directed bench for reg_file_mp against a behavioural model.
module tb_reg_file_mp;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NRD = 4;
  localparam int unsigned NWR = 2;
  localparam int unsigned NB = DW / 8;
  localparam int unsigned DEPTH = 2 ** AW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rf_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NRD), .NUM_WR(NWR)) bus ();

  reg_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NRD), .NUM_WR(NWR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model
  logic [DW-1:0] mem_m [DEPTH];
  bit            busy_m [DEPTH];
  bit            ready_m;
  int            init_edges;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] wa(input int i);
    return bus.waddr[i*AW +: AW];
  endfunction

  function automatic logic [AW-1:0] ra(input int j);
    return bus.raddr[j*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    if (!ready_m || a == 0) return '0;
    v = mem_m[a];
    for (int i = 0; i < NWR; i++)
      for (int b = 0; b < NB; b++)
        if (wa(i) == a && bus.byte_wen[i*NB + b]) v[b*8 +: 8] = bus.wdata[i*DW + b*8 +: 8];
    return v;
  endfunction

  function automatic bit exp_busy(input logic [AW-1:0] a);
    bit v;
    if (!ready_m) return 1'b0;
    v = busy_m[a];
    for (int i = 0; i < NWR; i++)
      if (bus.wclr[i] && wa(i) == a) v = 1'b0;
    return v;
  endfunction

  task automatic model_reset();
    ready_m = 1'b0;
    init_edges = 0;
    for (int a = 0; a < DEPTH; a++) busy_m[a] = 1'b0;
  endtask

  task automatic model_edge();
    if (!rst) return;
    if (!ready_m) begin
      init_edges++;
      if (init_edges == DEPTH - 1) begin
        ready_m = 1'b1;
        for (int a = 0; a < DEPTH; a++) mem_m[a] = '0;
      end
    end else begin
      for (int i = 0; i < NWR; i++)
        if (wa(i) != 0)
          for (int b = 0; b < NB; b++)
            if (bus.byte_wen[i*NB + b]) mem_m[wa(i)][b*8 +: 8] = bus.wdata[i*DW + b*8 +: 8];
      for (int i = 0; i < NWR; i++)
        if (bus.wclr[i]) busy_m[wa(i)] = 1'b0;
      if (bus.set_en && bus.set_addr != 0) busy_m[bus.set_addr] = 1'b1;
    end
  endtask

  // Check every output against the model, away from the clock edge
  task automatic settle();
    #1;
    for (int j = 0; j < NRD; j++) begin
      chk($sformatf("rdata%0d", j), 64'(bus.rdata[j*DW +: DW]), 64'(exp_read(ra(j))));
      chk($sformatf("rbusy%0d", j), 64'(bus.rbusy[j]), 64'(exp_busy(ra(j))));
    end
    chk("rf_ready", 64'(bus.rf_ready), 64'(ready_m));
  endtask

  task automatic adv();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic clear_in();
    bus.waddr = '0; bus.byte_wen = '0; bus.wdata = '0; bus.wclr = '0;
    bus.raddr = '0; bus.set_en = 1'b0; bus.set_addr = '0;
  endtask

  task automatic rand_in();
    for (int i = 0; i < NWR; i++) begin
      bus.waddr[i*AW +: AW] = AW'($urandom_range(0, 7));
      bus.byte_wen[i*NB +: NB] = NB'($urandom);
      bus.wdata[i*DW +: DW] = $urandom;
      bus.wclr[i] = ($urandom_range(0, 3) == 0);
    end
    for (int j = 0; j < NRD; j++) bus.raddr[j*AW +: AW] = AW'($urandom_range(0, 7));
    bus.set_en = ($urandom_range(0, 9) < 3);
    bus.set_addr = AW'($urandom_range(0, 7));
  endtask

  task automatic ready_sequence();
    for (int k = 0; k < DEPTH; k++) begin
      if (k < DEPTH - 1) rand_in(); else clear_in();
      settle();
      chk("ready_seq", 64'(bus.rf_ready), (k == DEPTH - 1) ? 64'd1 : 64'd0);
      adv();
    end
  endtask

  initial begin
    rst = 1'b0;
    clear_in();
    model_reset();
    repeat (2) @(negedge clk);
    settle();
    chk("reset_ready", 64'(bus.rf_ready), 64'd0);
    rst = 1'b1;

    // Sweep: ready low for 31 cycles, high on the 32nd
    ready_sequence();

    // Full-word write with same-cycle bypass, then stored value
    clear_in();
    bus.waddr[0 +: AW] = 5; bus.byte_wen[0 +: NB] = 4'hF; bus.wdata[0 +: DW] = 32'h11223344;
    bus.raddr[0 +: AW] = 5;
    settle();
    chk("bypass5", 64'(bus.rdata[0 +: DW]), 64'h11223344);
    adv();
    clear_in(); bus.raddr[0 +: AW] = 5;
    settle();
    chk("stored5", 64'(bus.rdata[0 +: DW]), 64'h11223344);
    adv();

    // Two ports, same address, overlapping byte: port 1 wins byte 0
    clear_in();
    bus.waddr[0 +: AW] = 7; bus.byte_wen[0 +: NB] = 4'hF; bus.wdata[0 +: DW] = 32'hAAAAAAAA;
    bus.waddr[AW +: AW] = 7; bus.byte_wen[NB +: NB] = 4'h1; bus.wdata[DW +: DW] = 32'h000000BB;
    bus.raddr[AW +: AW] = 7;
    settle();
    chk("bypass7", 64'(bus.rdata[DW +: DW]), 64'hAAAAAABB);
    adv();
    clear_in(); bus.raddr[AW +: AW] = 7;
    settle();
    chk("stored7", 64'(bus.rdata[DW +: DW]), 64'hAAAAAABB);
    adv();

    // Register 0: writes and busy set are discarded
    clear_in();
    for (int i = 0; i < NWR; i++) begin
      bus.byte_wen[i*NB +: NB] = 4'hF; bus.wdata[i*DW +: DW] = 32'hFFFFFFFF;
    end
    bus.set_en = 1'b1;
    settle();
    chk("r0_bypass", 64'(bus.rdata[0 +: DW]), 64'd0);
    adv();
    clear_in();
    settle();
    chk("r0_read", 64'(bus.rdata[2*DW +: DW]), 64'd0);
    chk("r0_busy", 64'(bus.rbusy[2]), 64'd0);
    adv();

    // Scoreboard on register 9
    clear_in(); bus.set_en = 1'b1; bus.set_addr = 9; bus.raddr[3*AW +: AW] = 9;
    settle();
    chk("busy9_setcycle", 64'(bus.rbusy[3]), 64'd0);
    adv();
    clear_in(); bus.raddr[3*AW +: AW] = 9;
    settle();
    chk("busy9_set", 64'(bus.rbusy[3]), 64'd1);
    adv();
    clear_in(); bus.wclr[1] = 1'b1; bus.waddr[AW +: AW] = 9; bus.raddr[3*AW +: AW] = 9;
    settle();
    chk("busy9_clrcycle", 64'(bus.rbusy[3]), 64'd0);
    adv();
    clear_in(); bus.raddr[3*AW +: AW] = 9;
    settle();
    chk("busy9_cleared", 64'(bus.rbusy[3]), 64'd0);
    adv();
    clear_in(); bus.set_en = 1'b1; bus.set_addr = 9;
    bus.wclr[0] = 1'b1; bus.waddr[0 +: AW] = 9; bus.raddr[3*AW +: AW] = 9;
    settle();
    adv();
    clear_in(); bus.raddr[3*AW +: AW] = 9;
    settle();
    chk("busy9_setwins", 64'(bus.rbusy[3]), 64'd1);
    adv();

    // Random traffic with occasional resets
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 599) == 0) begin
        rst = 1'b0;
        model_reset();
        clear_in();
        settle();
        adv();
        rst = 1'b1;
      end
      rand_in();
      settle();
      adv();
    end

    // Drain any sweep left by a late random reset
    clear_in();
    for (int n = 0; n < DEPTH + 2 && !ready_m; n++) begin
      settle();
      adv();
    end

    // Reset in the middle of a sweep
    clear_in(); bus.set_en = 1'b1; bus.set_addr = 9;
    bus.waddr[0 +: AW] = 5; bus.byte_wen[0 +: NB] = 4'hF; bus.wdata[0 +: DW] = 32'h55;
    settle();
    adv();
    rst = 1'b0; model_reset(); clear_in();
    settle();
    adv();
    rst = 1'b1;
    for (int n = 0; n < 9; n++) begin
      rand_in();
      settle();
      adv();
    end
    rst = 1'b0; model_reset(); clear_in();
    settle();
    chk("midsweep_ready", 64'(bus.rf_ready), 64'd0);
    adv();
    rst = 1'b1;
    ready_sequence();
    clear_in(); bus.raddr[0 +: AW] = 5; bus.raddr[3*AW +: AW] = 9;
    settle();
    chk("after_reset_r5", 64'(bus.rdata[0 +: DW]), 64'd0);
    chk("after_reset_busy9", 64'(bus.rbusy[3]), 64'd0);
    adv();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
